// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: RV32I access-width codes and FSM states.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide request/ready data-memory bus between the LSU (master) and memory (slave).
interface load_store_unit_if;

  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [3:0]  MemWStrb;
  logic        MemReady;
  logic [31:0] MemRData;

  modport master (
    output MemReq, MemWe, MemAddr, MemWData, MemWStrb,
    input  MemReady, MemRData
  );

  modport slave (
    input  MemReq, MemWe, MemAddr, MemWData, MemWStrb,
    output MemReady, MemRData
  );

endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: store strobe/replication, legality check, and load extraction/extension.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic        req_load,
  input  logic [2:0]  req_f3,
  input  logic [1:0]  req_off,
  input  logic [31:0] store_data,
  output logic [3:0]  strb,
  output logic [31:0] wdata_rep,
  output logic        misalign,
  input  logic [2:0]  rsp_f3,
  input  logic [1:0]  rsp_off,
  input  logic [31:0] rdata,
  output logic [31:0] load_ext
);

  logic        legal;
  logic [31:0] shifted;

  always_comb begin
    legal = 1'b0;
    if (req_load)
      legal = (req_f3 == F3_B) || (req_f3 == F3_H) || (req_f3 == F3_W) ||
              (req_f3 == F3_BU) || (req_f3 == F3_HU);
    else
      legal = (req_f3 == F3_B) || (req_f3 == F3_H) || (req_f3 == F3_W);

    misalign = !legal ||
               ((req_f3[1:0] == 2'b01) && req_off[0]) ||
               ((req_f3[1:0] == 2'b10) && (req_off != 2'b00));
  end

  always_comb begin
    strb      = '0;
    wdata_rep = store_data;
    case (req_f3[1:0])
      2'b00: begin
        strb      = 4'b0001 << req_off;
        wdata_rep = {4{store_data[7:0]}};
      end
      2'b01: begin
        strb      = req_off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{store_data[15:0]}};
      end
      2'b10: strb = 4'b1111;
      default: strb = '0;
    endcase
  end

  always_comb begin
    shifted = rdata >> {rsp_off, 3'b000};
    case (rsp_f3)
      F3_B:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_ext = {24'h0, shifted[7:0]};
      F3_HU:   load_ext = {16'h0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: issues one bus access per load/store, stalls the core until it completes or times out.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] AluOutput,
  input  logic [31:0] ReadData2,
  output logic        Stall,
  output logic [31:0] LoadData,
  output logic        Misalign,
  output logic        BusErr,
  load_store_unit_if.master bus
);

  lsu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             mem_req, mem_we;
  logic [31:0]      mem_addr, mem_wdata;
  logic [3:0]       mem_wstrb;
  logic [2:0]       lat_f3;
  logic [1:0]       lat_off;
  logic [31:0]      load_data;
  logic             bus_err;

  logic             access;
  logic             bad;
  logic [3:0]       strb;
  logic [31:0]      wdata_rep;
  logic [31:0]      load_ext;

  assign access = MemRead | MemWrite;

  // Request-side inputs come straight from the core; response side uses the latched access.
  load_store_unit_align u_align (
    .req_load   (MemRead),
    .req_f3     (Funct3),
    .req_off    (AluOutput[1:0]),
    .store_data (ReadData2),
    .strb       (strb),
    .wdata_rep  (wdata_rep),
    .misalign   (bad),
    .rsp_f3     (lat_f3),
    .rsp_off    (lat_off),
    .rdata      (bus.MemRData),
    .load_ext   (load_ext)
  );

  assign Stall    = (state == BUSY) || ((state == IDLE) && access && !bad);
  assign Misalign = (state == IDLE) && access && bad;
  assign LoadData = load_data;
  assign BusErr   = bus_err;

  assign bus.MemReq   = mem_req;
  assign bus.MemWe    = mem_we;
  assign bus.MemAddr  = mem_addr;
  assign bus.MemWData = mem_wdata;
  assign bus.MemWStrb = mem_wstrb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      lat_f3    <= '0;
      lat_off   <= '0;
      load_data <= '0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (access && !bad) begin
            state     <= BUSY;
            cnt       <= '0;
            mem_req   <= 1'b1;
            mem_we    <= !MemRead;
            mem_addr  <= {AluOutput[31:2], 2'b00};
            mem_wdata <= wdata_rep;
            mem_wstrb <= MemRead ? 4'b0000 : strb;
            lat_f3    <= Funct3;
            lat_off   <= AluOutput[1:0];
          end
        end
        BUSY: begin
          cnt <= cnt + CNT_W'(1);
          if (bus.MemReady) begin
            state   <= DONE;
            mem_req <= 1'b0;
            if (!mem_we)
              load_data <= load_ext;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state     <= ERR;
            mem_req   <= 1'b0;
            bus_err   <= 1'b1;
            load_data <= '0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
